fsk_encoder: RTL and testbench

Transmit-side FSK modulator: accepts a parallel data word over a valid/ready handshake and serialises it MSB-first as a square-wave carrier on a single line. A `1` bit is a short carrier half-period and a `0` bit is a long one. The half-periods are chosen so the receive-side FSK decoder's high-phase width threshold (high < 7 clk ⇒ `1`) recovers each bit. The block sits in the TX path, driving the channel line that the decoder samples.

---
 rtl/fsk_encoder.sv | 136 +++++++++++++
 tb/tb_fsk_encoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fsk_encoder.sv
// FSK transmit modulator: serialises a parallel word MSB-first as a square-wave carrier.
// Optional 1010 preamble ahead of the data when FSK_ENC_PREAMBLE_EN is defined.
module fsk_encoder #(
    parameter int DATA_W      = 8,
    parameter int HALF_1      = 4,
    parameter int HALF_0      = 10,
    parameter int CYC_PER_BIT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              codeout,
    output logic              busy,
    output logic              bit_done
);

`ifdef FSK_ENC_PREAMBLE_EN
    localparam int PRE_W = 4;
    localparam logic [PRE_W-1:0] PREAMBLE = 4'b1010;
`else
    localparam int PRE_W = 0;
`endif
    localparam int SR_W = DATA_W + PRE_W;
    localparam int HC_W = $clog2(HALF_0 + 1);
    localparam int BC_W = $clog2(SR_W + 1);
    localparam int PC_W = $clog2(CYC_PER_BIT + 1);

    // PRE is the high phase of a preamble bit; LOW is shared by preamble and data.
`ifdef FSK_ENC_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE, HIGH, LOW, PRE} state_t;
`else
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
`endif

    state_t            state_q, state_d;
    state_t            hi_cur, hi_nxt, hi_first;
    logic [SR_W-1:0]   sreg_q, sreg_d, load_word;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;
    logic              bit_done_d, codeout_d;

    function automatic logic [HC_W-1:0] half_of(input logic b);
        return b ? HC_W'(HALF_1 - 1) : HC_W'(HALF_0 - 1);
    endfunction

`ifdef FSK_ENC_PREAMBLE_EN
    // While more than DATA_W bits remain, the bit on the line belongs to the preamble.
    assign load_word = {PREAMBLE, tx_data};
    assign hi_first  = PRE;
    assign hi_cur    = (bcnt_q > BC_W'(DATA_W))     ? PRE : HIGH;
    assign hi_nxt    = (bcnt_q > BC_W'(DATA_W + 1)) ? PRE : HIGH;
`else
    assign load_word = tx_data;
    assign hi_first  = HIGH;
    assign hi_cur    = HIGH;
    assign hi_nxt    = HIGH;
`endif

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        bcnt_d     = bcnt_q;
        pcnt_d     = pcnt_q;
        hcnt_d     = hcnt_q;
        bit_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    sreg_d  = load_word;
                    bcnt_d  = BC_W'(SR_W);
                    pcnt_d  = PC_W'(CYC_PER_BIT);
                    hcnt_d  = half_of(load_word[SR_W-1]);
                    state_d = hi_first;
                end
            end
            LOW: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - 1'b1;
                end else if (pcnt_q > PC_W'(1)) begin
                    pcnt_d  = pcnt_q - 1'b1;
                    hcnt_d  = half_of(sreg_q[SR_W-1]);
                    state_d = hi_cur;
                end else begin
                    bit_done_d = 1'b1;
                    sreg_d     = sreg_q << 1;
                    bcnt_d     = bcnt_q - 1'b1;
                    if (bcnt_q > BC_W'(1)) begin
                        pcnt_d  = PC_W'(CYC_PER_BIT);
                        hcnt_d  = half_of(sreg_d[SR_W-1]);
                        state_d = hi_nxt;
                    end else begin
                        pcnt_d  = '0;
                        hcnt_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                if (hcnt_q != '0) begin
                    hcnt_d = hcnt_q - 1'b1;
                end else begin
                    hcnt_d  = half_of(sreg_q[SR_W-1]);
                    state_d = LOW;
                end
            end
        endcase
        codeout_d = (state_d != IDLE) && (state_d != LOW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            bcnt_q   <= '0;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            bit_done <= 1'b0;
            codeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            bcnt_q   <= bcnt_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            bit_done <= bit_done_d;
            codeout  <= codeout_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_fsk_encoder.sv
// Directed bench for fsk_encoder: high widths, frame length, bit_done count, back-to-back, reset.
// Honours FSK_ENC_PREAMBLE_EN by prepending 1010 to the expected bit stream.
module tb_fsk_encoder;
    localparam int DATA_W = 8;
    localparam int HALF_1 = 4;
    localparam int HALF_0 = 10;
    localparam int CYC    = 2;
    localparam int BUDGET = 2000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready, codeout, busy, bit_done;

    int n_tests = 0;
    int n_fail  = 0;

    fsk_encoder #(.DATA_W(DATA_W), .HALF_1(HALF_1), .HALF_0(HALF_0), .CYC_PER_BIT(CYC)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .codeout(codeout), .busy(busy), .bit_done(bit_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; raises tx_valid and returns just after the accepting posedge.
    task automatic send(input logic [DATA_W-1:0] d, input logic hold, output int waited);
        tx_data  = d;
        tx_valid = 1'b1;
        waited   = 0;
        while (!tx_ready && waited < BUDGET) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Follows one frame from its accept edge to the idle gap, checking against a bit-level model.
    task automatic watch(input logic [DATA_W-1:0] d, input int poke_at, input int abort_at,
                         input string tag);
        logic [7:0] exp_q[$];
        logic [DATA_W+3:0] bits;
        int nbits, exp_len, n, run, dones, hw;
        logic aborted;
`ifdef FSK_ENC_PREAMBLE_EN
        bits  = {4'b1010, d};
        nbits = DATA_W + 4;
`else
        bits  = {4'b0000, d};
        nbits = DATA_W;
`endif
        exp_len = 0;
        for (int b = nbits - 1; b >= 0; b--) begin
            hw = bits[b] ? HALF_1 : HALF_0;
            for (int p = 0; p < CYC; p++) exp_q.push_back(8'(hw));
            exp_len += 2 * hw * CYC;
        end
        n = 0; run = 0; dones = 0; aborted = 1'b0;
        while (n < BUDGET) begin
            @(negedge clk);
            if (bit_done) dones++;
            if (tx_ready) break;
            n++;
            if (codeout) begin
                run++;
            end else if (run > 0) begin
                if (exp_q.size() > 0) check($sformatf("%s_width", tag), run, exp_q.pop_front());
                else check($sformatf("%s_extra_pulse", tag), run, 0);
                run = 0;
            end
            if (n == poke_at) begin
                tx_valid = 1'b1;
                tx_data  = ~d;
            end else if (n == poke_at + 1) begin
                tx_valid = 1'b0;
            end
            if (n == abort_at) begin
                check($sformatf("%s_pre_reset_high", tag), codeout, 1);
                reset = 1'b0;
                #1;
                check($sformatf("%s_rst_codeout", tag), codeout, 0);
                check($sformatf("%s_rst_ready", tag), tx_ready, 1);
                check($sformatf("%s_rst_busy", tag), busy, 0);
                check($sformatf("%s_rst_bit_done", tag), bit_done, 0);
                @(negedge clk);
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            check($sformatf("%s_length", tag), n, exp_len);
            check($sformatf("%s_bit_done", tag), dones, nbits);
            check($sformatf("%s_pulses_left", tag), exp_q.size(), 0);
            check($sformatf("%s_gap_low", tag), codeout, 0);
            check($sformatf("%s_gap_busy", tag), busy, 0);
        end
    endtask

    initial begin
        int waited;
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_codeout", codeout, 0);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_bit_done", bit_done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic frame
        send(8'hA5, 1'b0, waited);
        check("a5_line_high_at_accept", codeout, 1);
        check("a5_ready_low_at_accept", tx_ready, 0);
        watch(8'hA5, -10, -10, "a5");

        // Back-to-back with tx_valid held high
        @(negedge clk);
        send(8'hFF, 1'b1, waited);
        watch(8'hFF, -10, -10, "b2b_ff");
        send(8'h00, 1'b0, waited);
        check("b2b_no_wait", waited, 0);
        watch(8'h00, -10, -10, "b2b_00");

        // tx_valid pulse mid-frame is ignored
        @(negedge clk);
        send(8'h96, 1'b0, waited);
        watch(8'h96, 30, -10, "poke");

        // Reset at clock 50 of a 0x00 frame, then a clean 0xFF
        @(negedge clk);
        send(8'h00, 1'b0, waited);
        watch(8'h00, -10, 50, "abort");
        send(8'hFF, 1'b0, waited);
        watch(8'hFF, -10, -10, "after_rst");

        // Further patterns
        @(negedge clk);
        send(8'h3C, 1'b0, waited);
        watch(8'h3C, -10, -10, "x3c");
        @(negedge clk);
        send(8'hC3, 1'b0, waited);
        watch(8'hC3, -10, -10, "xc3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
